// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run/step sequencer for the single-cycle rv32is core.
// Gates the CPU clock enable, drives the CPU's active-high reset, counts
// executed cycles and stops the core on pass/fail magic values in a0, a
// PC breakpoint, step exhaustion, cycle timeout or a host HALT command.
// Optional feature macro: CPU_RUN_CTRL_TRACE_EN adds a registered
// trace_valid/trace_pc pair describing each enabled CPU edge.
module cpu_run_ctrl #(
   parameter int unsigned MAX_CYCLES   = 10000,
   parameter int unsigned RESET_CYCLES = 1,
   parameter logic [31:0] PASS_MAGIC   = 32'h00c0ffee,
   parameter logic [31:0] FAIL_MAGIC   = 32'hdeaddead
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_op,
   input  logic [15:0] cmd_arg,
   input  logic [31:0] pc,
   input  logic [31:0] a0,
   input  logic        bp_en,
   input  logic [31:0] bp_addr,
   output logic        cpu_clk_en,
   output logic        cpu_reset,
   output logic [2:0]  state,
   output logic [31:0] cycle_count,
   output logic        pass,
   output logic        fail,
   output logic        timeout,
   output logic        bp_hit
`ifdef CPU_RUN_CTRL_TRACE_EN
   ,
   output logic        trace_valid,
   output logic [31:0] trace_pc
`endif
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_CPURST = 3'd1,
      S_STEP   = 3'd2,
      S_RUN    = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   typedef enum logic [1:0] {
      OP_RESET_CPU = 2'b00,
      OP_STEP      = 2'b01,
      OP_RUN       = 2'b10,
      OP_HALT      = 2'b11
   } op_t;

   typedef enum logic [2:0] {
      STOP_NONE, STOP_FAIL, STOP_PASS, STOP_BP, STOP_TIMEOUT, STOP_STEP
   } stop_t;

   // A zero RESET_CYCLES would never reset the CPU; clamp it to one.
   localparam int unsigned RST_CYC = (RESET_CYCLES < 1) ? 1 : RESET_CYCLES;

   state_t      state_q, state_next;
   stop_t       cause;
   logic [31:0] rst_cnt;
   logic [15:0] step_cnt;
   logic        first_q;
   logic        active, stop_now, exec_en, accept, start_rst, start_exec;

   assign active     = (state_q == S_STEP) || (state_q == S_RUN);
   assign stop_now   = (cause != STOP_NONE);
   assign exec_en    = active && !stop_now;
   assign cpu_clk_en = (state_q == S_CPURST) || exec_en;
   assign state      = state_q;

   assign cmd_ready  = reset && ((state_q == S_IDLE) || (state_q == S_DONE) ||
                                 (active && (cmd_op == OP_HALT)));
   assign accept     = cmd_valid && cmd_ready;
   assign start_rst  = accept && (cmd_op == OP_RESET_CPU);
   assign start_exec = accept && (state_q == S_IDLE) &&
                       ((cmd_op == OP_STEP) || (cmd_op == OP_RUN));

   // Stop-cause decode in priority order; the breakpoint is masked in the
   // first cycle of a STEP/RUN so the core can step off a breakpointed PC.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      cause = STOP_NONE;
      if (active) begin
         if (a0 == FAIL_MAGIC)                          cause = STOP_FAIL;
         else if (a0 == PASS_MAGIC)                     cause = STOP_PASS;
         else if (bp_en && !first_q && pc == bp_addr)   cause = STOP_BP;
         else if (cycle_count == 32'(MAX_CYCLES))       cause = STOP_TIMEOUT;
         else if (state_q == S_STEP && step_cnt == '0)  cause = STOP_STEP;
      end
   end

   // Next-state logic; stop conditions win over a HALT in the same cycle.
   always_comb begin
      state_next = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (accept) begin
               unique case (cmd_op)
                  OP_RESET_CPU: state_next = S_CPURST;
                  OP_STEP:      state_next = S_STEP;
                  OP_RUN:       state_next = S_RUN;
                  default:      state_next = S_IDLE;
               endcase
            end
         end
         S_CPURST: if (rst_cnt == '0) state_next = S_IDLE;
         S_STEP, S_RUN: begin
            if (stop_now) begin
               state_next = (cause == STOP_BP || cause == STOP_STEP) ? S_IDLE : S_DONE;
            end else if (accept) begin
               state_next = S_IDLE;
            end
         end
         S_DONE: if (start_rst) state_next = S_CPURST;
         default: state_next = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clock or negedge reset) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_next;
   end

   // CPU reset is held while in CPURST and stays high out of controller reset.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) cpu_reset <= 1'b1;
      else        cpu_reset <= (state_next == S_CPURST);
   end

   // Reset-length counter, step counter and first-cycle marker.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rst_cnt  <= '0;
         step_cnt <= '0;
         first_q  <= 1'b0;
      end else begin
         if (start_rst)                               rst_cnt <= 32'(RST_CYC - 1);
         else if (state_q == S_CPURST && rst_cnt != '0) rst_cnt <= rst_cnt - 32'd1;

         if (start_exec && cmd_op == OP_STEP)         step_cnt <= (cmd_arg == '0) ? 16'd1 : cmd_arg;
         else if (state_q == S_STEP && exec_en)       step_cnt <= step_cnt - 16'd1;

         first_q <= start_exec;
      end
   end

   // Saturating count of enabled execution cycles since the last RESET_CPU.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)                              cycle_count <= '0;
      else if (start_rst)                      cycle_count <= '0;
      else if (exec_en && cycle_count != '1)   cycle_count <= cycle_count + 32'd1;
   end

   // Sticky stop-cause flags; only the winning cause is recorded.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pass <= 1'b0; fail <= 1'b0; timeout <= 1'b0; bp_hit <= 1'b0;
      end else if (start_rst) begin
         pass <= 1'b0; fail <= 1'b0; timeout <= 1'b0; bp_hit <= 1'b0;
      end else begin
         if (start_exec) bp_hit <= 1'b0;
         unique case (cause)
            STOP_FAIL:    fail    <= 1'b1;
            STOP_PASS:    pass    <= 1'b1;
            STOP_BP:      bp_hit  <= 1'b1;
            STOP_TIMEOUT: timeout <= 1'b1;
            default: ;
         endcase
      end
   end

`ifdef CPU_RUN_CTRL_TRACE_EN
   // Trace of each enabled CPU edge, visible one cycle after the edge.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         trace_valid <= 1'b0;
         trace_pc    <= '0;
      end else begin
         trace_valid <= cpu_clk_en;
         if (cpu_clk_en) trace_pc <= pc;
      end
   end
`endif

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// tb_cpu_run_ctrl: directed self-checking bench for cpu_run_ctrl.
// A tiny CPU model (PC +4 per enabled edge, reset vector 0x24) drives pc,
// and a0 is driven from the model's own count of executed cycles.
module tb_cpu_run_ctrl;

   localparam logic [31:0] PASS_V = 32'h00c0ffee;
   localparam logic [31:0] FAIL_V = 32'hdeaddead;

   logic        clock = 1'b0;
   logic        reset;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [1:0]  cmd_op;
   logic [15:0] cmd_arg;
   logic [31:0] pc, a0;
   logic        bp_en;
   logic [31:0] bp_addr;
   logic        cpu_clk_en, cpu_reset;
   logic [2:0]  state;
   logic [31:0] cycle_count;
   logic        pass, fail, timeout, bp_hit;

   int n_cmp = 0;
   int n_bad = 0;

   // CPU model state
   logic [31:0] mpc      = 32'h0;
   int unsigned mcount   = 0;
   int unsigned en_total = 0;
   int          a0_mode  = 0;

   cpu_run_ctrl #(.MAX_CYCLES(20), .RESET_CYCLES(1)) dut (
      .clock(clock), .reset(reset),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
      .pc(pc), .a0(a0), .bp_en(bp_en), .bp_addr(bp_addr),
      .cpu_clk_en(cpu_clk_en), .cpu_reset(cpu_reset), .state(state),
      .cycle_count(cycle_count), .pass(pass), .fail(fail), .timeout(timeout), .bp_hit(bp_hit)
   );

   always #5 clock = ~clock;

   // CPU model: advances only on enabled edges.
   always @(posedge clock) begin
      if (cpu_clk_en) begin
         if (cpu_reset) begin
            mpc    <= 32'h24;
            mcount <= 0;
         end else begin
            mpc      <= mpc + 32'd4;
            mcount   <= mcount + 1;
            en_total <= en_total + 1;
         end
      end
   end

   assign pc = mpc;
   always_comb begin
      a0 = 32'h0;
      if (a0_mode == 1 && mcount == 12) a0 = PASS_V;
      if (a0_mode == 2 && mcount == 20) a0 = FAIL_V;
   end

   task automatic send_cmd(input logic [1:0] op, input logic [15:0] arg);
      @(negedge clock);
      cmd_valid = 1'b1; cmd_op = op; cmd_arg = arg;
      @(negedge clock);
      cmd_valid = 1'b0;
   endtask

   task automatic wait_leave(input logic [2:0] s, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (state !== s) begin ok = 1'b1; break; end
         @(negedge clock);
      end
   endtask

   task automatic test_reset;
      bit [5:0] got;
      #12;
      got = {state, cpu_reset, cpu_clk_en, cmd_ready};
      n_cmp++;
      if (got !== {3'd0, 1'b1, 1'b0, 1'b0}) begin
         $display("FAIL reset_status: got %h expected %h", got, {3'd0, 1'b1, 1'b0, 1'b0}); n_bad++;
      end
      n_cmp++;
      if ({cycle_count, pass, fail, timeout, bp_hit} !== 36'h0) begin
         $display("FAIL reset_count_flags: got count %h flags %b expected 0", cycle_count, {pass, fail, timeout, bp_hit}); n_bad++;
      end
      @(negedge clock);
      reset = 1'b1;
      #1;
      n_cmp++;
      if ({cpu_reset, cmd_ready} !== 2'b11) begin
         $display("FAIL release_hold: got cpu_reset,ready=%b expected 11", {cpu_reset, cmd_ready}); n_bad++;
      end
      @(negedge clock);
      n_cmp++;
      if ({state, cpu_reset, cpu_clk_en} !== {3'd0, 1'b0, 1'b0}) begin
         $display("FAIL release_first_edge: got state %0d cpu_reset %b en %b expected 0 0 0", state, cpu_reset, cpu_clk_en); n_bad++;
      end
   endtask

   task automatic test_reset_cpu;
      @(negedge clock);
      cmd_valid = 1'b1; cmd_op = 2'b00; cmd_arg = 16'h0;
      #1;
      n_cmp++;
      if (cmd_ready !== 1'b1) begin
         $display("FAIL idle_ready: got %b expected 1", cmd_ready); n_bad++;
      end
      @(negedge clock);
      cmd_valid = 1'b0;
      n_cmp++;
      if ({state, cpu_reset, cpu_clk_en, cmd_ready} !== {3'd1, 1'b1, 1'b1, 1'b0}) begin
         $display("FAIL cpurst_cycle: got %h expected %h", {state, cpu_reset, cpu_clk_en, cmd_ready}, {3'd1, 1'b1, 1'b1, 1'b0}); n_bad++;
      end
      @(negedge clock);
      n_cmp++;
      if ({state, cpu_reset, cpu_clk_en, cmd_ready} !== {3'd0, 1'b0, 1'b0, 1'b1} || cycle_count !== 32'd0) begin
         $display("FAIL cpurst_done: got status %h count %0d expected %h count 0", {state, cpu_reset, cpu_clk_en, cmd_ready}, cycle_count, {3'd0, 1'b0, 1'b0, 1'b1}); n_bad++;
      end
   endtask

   task automatic test_step;
      int unsigned base;
      bit ok;
      base = en_total;
      send_cmd(2'b01, 16'd3);
      wait_leave(3'd2, 20, ok);
      n_cmp++;
      if (!ok || state !== 3'd0) begin
         $display("FAIL step3_end: got state %0d (left=%0d) expected 0", state, ok); n_bad++;
      end
      n_cmp++;
      if (en_total - base !== 3 || cycle_count !== 32'd3) begin
         $display("FAIL step3_count: got edges %0d count %0d expected 3 3", en_total - base, cycle_count); n_bad++;
      end
      base = en_total;
      send_cmd(2'b01, 16'd0);
      wait_leave(3'd2, 20, ok);
      n_cmp++;
      if (!ok || en_total - base !== 1 || cycle_count !== 32'd4 || state !== 3'd0) begin
         $display("FAIL step0: got edges %0d count %0d state %0d expected 1 4 0", en_total - base, cycle_count, state); n_bad++;
      end
   endtask

   task automatic test_run_pass;
      int unsigned base;
      bit left;
      a0_mode = 1;
      send_cmd(2'b10, 16'd0);
      left = 1'b0;
      for (int i = 0; i < 60; i++) begin
         if (state !== 3'd3) begin left = 1'b1; break; end
         if (mcount == 12) begin
            n_cmp++;
            if (cpu_clk_en !== 1'b0) begin
               $display("FAIL pass_en_drop: got en %b expected 0", cpu_clk_en); n_bad++;
            end
         end
         @(negedge clock);
      end
      n_cmp++;
      if (!left || state !== 3'd4 || {pass, fail, timeout, bp_hit} !== 4'b1000 || cycle_count !== 32'd12) begin
         $display("FAIL run_pass: got state %0d flags %b count %0d expected 4 1000 12", state, {pass, fail, timeout, bp_hit}, cycle_count); n_bad++;
      end
      base = en_total;
      send_cmd(2'b10, 16'd0);
      repeat (3) @(negedge clock);
      n_cmp++;
      if (state !== 3'd4 || cpu_clk_en !== 1'b0 || cycle_count !== 32'd12 || en_total != base) begin
         $display("FAIL done_ignore_run: got state %0d en %b count %0d edges %0d expected 4 0 12 0", state, cpu_clk_en, cycle_count, en_total - base); n_bad++;
      end
   endtask

   task automatic test_breakpoint;
      int unsigned base;
      bit ok;
      a0_mode = 0;
      send_cmd(2'b00, 16'd0);
      wait_leave(3'd1, 10, ok);
      bp_en = 1'b1; bp_addr = 32'h44;
      send_cmd(2'b10, 16'd0);
      wait_leave(3'd3, 60, ok);
      n_cmp++;
      if (!ok || state !== 3'd0 || {pass, fail, timeout, bp_hit} !== 4'b0001 || cycle_count !== 32'd8) begin
         $display("FAIL bp_stop: got state %0d flags %b count %0d expected 0 0001 8", state, {pass, fail, timeout, bp_hit}, cycle_count); n_bad++;
      end
      base = en_total;
      send_cmd(2'b01, 16'd1);
      wait_leave(3'd2, 20, ok);
      n_cmp++;
      if (!ok || state !== 3'd0 || bp_hit !== 1'b0 || cycle_count !== 32'd9 || en_total - base !== 1) begin
         $display("FAIL bp_step_over: got state %0d bp_hit %b count %0d edges %0d expected 0 0 9 1", state, bp_hit, cycle_count, en_total - base); n_bad++;
      end
      bp_en = 1'b0;
   endtask

   task automatic test_timeout;
      bit ok;
      a0_mode = 0;
      send_cmd(2'b00, 16'd0);
      wait_leave(3'd1, 10, ok);
      send_cmd(2'b10, 16'd0);
      wait_leave(3'd3, 60, ok);
      n_cmp++;
      if (!ok || state !== 3'd4 || {pass, fail, timeout, bp_hit} !== 4'b0010 || cycle_count !== 32'd20) begin
         $display("FAIL timeout: got state %0d flags %b count %0d expected 4 0010 20", state, {pass, fail, timeout, bp_hit}, cycle_count); n_bad++;
      end
      a0_mode = 2;
      send_cmd(2'b00, 16'd0);
      wait_leave(3'd1, 10, ok);
      send_cmd(2'b10, 16'd0);
      wait_leave(3'd3, 60, ok);
      n_cmp++;
      if (!ok || state !== 3'd4 || {pass, fail, timeout, bp_hit} !== 4'b0100 || cycle_count !== 32'd20) begin
         $display("FAIL fail_over_timeout: got state %0d flags %b count %0d expected 4 0100 20", state, {pass, fail, timeout, bp_hit}, cycle_count); n_bad++;
      end
      a0_mode = 0;
   endtask

   task automatic test_halt;
      bit ok;
      send_cmd(2'b00, 16'd0);
      wait_leave(3'd1, 10, ok);
      send_cmd(2'b10, 16'd0);
      ok = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (mcount == 5) begin ok = 1'b1; break; end
         @(negedge clock);
      end
      cmd_op = 2'b10;
      #1;
      n_cmp++;
      if (!ok || cmd_ready !== 1'b0) begin
         $display("FAIL run_ready_non_halt: got ready %b (reached=%0d) expected 0", cmd_ready, ok); n_bad++;
      end
      cmd_valid = 1'b1; cmd_op = 2'b11;
      #1;
      n_cmp++;
      if ({cmd_ready, cpu_clk_en} !== 2'b11) begin
         $display("FAIL halt_ready: got ready,en %b expected 11", {cmd_ready, cpu_clk_en}); n_bad++;
      end
      @(negedge clock);
      cmd_valid = 1'b0;
      n_cmp++;
      if (state !== 3'd0 || cpu_clk_en !== 1'b0 || cycle_count !== 32'd6) begin
         $display("FAIL halt_accept: got state %0d en %b count %0d expected 0 0 6", state, cpu_clk_en, cycle_count); n_bad++;
      end
      repeat (4) @(negedge clock);
      n_cmp++;
      if (cycle_count !== 32'd6 || mcount != 6) begin
         $display("FAIL halt_no_advance: got count %0d model %0d expected 6 6", cycle_count, mcount); n_bad++;
      end
   endtask

   task automatic test_reset_midrun;
      send_cmd(2'b10, 16'd0);
      repeat (3) @(negedge clock);
      @(posedge clock);
      #2;
      reset = 1'b0;
      #1;
      n_cmp++;
      if ({state, cpu_reset, cpu_clk_en, cmd_ready} !== {3'd0, 1'b1, 1'b0, 1'b0} ||
          cycle_count !== 32'd0 || {pass, fail, timeout, bp_hit} !== 4'b0000) begin
         $display("FAIL midrun_reset: got status %h count %0d flags %b expected %h 0 0000",
                  {state, cpu_reset, cpu_clk_en, cmd_ready}, cycle_count, {pass, fail, timeout, bp_hit}, {3'd0, 1'b1, 1'b0, 1'b0});
         n_bad++;
      end
      @(negedge clock);
      reset = 1'b1;
      repeat (2) @(negedge clock);
   endtask

   initial begin
      reset = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_arg = 16'h0;
      bp_en = 1'b0; bp_addr = 32'h0;
      test_reset();
      test_reset_cpu();
      test_step();
      test_run_pass();
      test_breakpoint();
      test_timeout();
      test_halt();
      test_reset_midrun();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

endmodule
